// File: rtl/filter_pkg.sv
// Shared filter codes, key indices and wrap-around stepping helpers
// for the pushbutton filter selector.
package filter_pkg;

  typedef enum logic [1:0] {
    FILT_NONE = 2'd0,
    FILT_A    = 2'd1,
    FILT_B    = 2'd2,
    FILT_C    = 2'd3
  } filter_t;

  localparam int KEY_NEXT  = 0;
  localparam int KEY_PREV  = 1;
  localparam int KEY_CLEAR = 2;

  function automatic filter_t filter_step_fwd(input filter_t f);
    return filter_t'(f + 2'd1);
  endfunction

  function automatic filter_t filter_step_back(input filter_t f);
    return filter_t'(f - 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop sync, stability counter, registered press pulse.
// Latency 2 + DEBOUNCE_CYCLES clocks from a clean edge to the pulse; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_raw,
  output logic key_level,
  output logic press_pulse
);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n_raw;
      sync2 <= sync1;
    end
  end

  // Any return to the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level   <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_level   <= sync2;
        cnt         <= '0;
        press_pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/difficulty_filter_fsm.sv
// Debounced pushbutton selector stepping a 4-state filter FSM (Moore output).
// filter_type updates one clock after a press pulse; CLEAR has top priority, no backpressure.
module difficulty_filter_fsm
  import filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic [1:0] filter_type
);

  logic [3:0] key_level;
  logic [3:0] press_pulse;
  logic       unused_bits;

  filter_t state;
  filter_t state_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DEB_W          (DEB_W)
    ) u_key_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n_raw  (key[i]),
      .key_level  (key_level[i]),
      .press_pulse(press_pulse[i])
    );
  end

  // Levels and the reserved key's pulse are synchronised but not acted on.
  assign unused_bits = ^{key_level, press_pulse[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILT_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (press_pulse[KEY_CLEAR]) begin
      state_nxt = FILT_NONE;
    end else if (press_pulse[KEY_NEXT] && !press_pulse[KEY_PREV]) begin
      state_nxt = filter_step_fwd(state);
    end else if (press_pulse[KEY_PREV] && !press_pulse[KEY_NEXT]) begin
      state_nxt = filter_step_back(state);
    end
  end

  assign filter_type = state;

endmodule

// File: tb/tb_difficulty_filter_fsm.sv
// Directed bench for difficulty_filter_fsm with DEBOUNCE_CYCLES = 4.
module tb_difficulty_filter_fsm;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [1:0] filter_type;

  int checks = 0;
  int errors = 0;

  difficulty_filter_fsm #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .filter_type(filter_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    int          hold;
    int          rel;
    logic [1:0]  exp_ft;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press the masked keys for hold cycles, release for rel cycles; a change
  // must land exactly LAT cycles after the press, otherwise none at all.
  task automatic apply(input vec_t v);
    logic [1:0] start;
    int         lat;
    start = filter_type;
    lat   = 0;
    key   = ~v.mask;
    for (int c = 1; c <= v.hold + v.rel; c++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && filter_type !== start) lat = c;
      if (c == v.hold) key = 4'hF;
    end
    chk({v.name, " value"}, int'(filter_type), int'(v.exp_ft));
    chk({v.name, " latency"}, lat, (v.exp_ft != start) ? LAT : 0);
  endtask

  task automatic bounce(input int segs);
    for (int s = 0; s < segs; s++) begin
      key[0] = s[0];
      cycles(2);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 10, 10, 2'd1, "next1"};
    vecs[1]  = '{4'b0001, 10, 10, 2'd2, "next2"};
    vecs[2]  = '{4'b0001, 10, 10, 2'd3, "next3"};
    vecs[3]  = '{4'b0001, 10, 10, 2'd0, "next_wrap"};
    vecs[4]  = '{4'b0010, 10, 10, 2'd3, "prev_wrap"};
    vecs[5]  = '{4'b0010, 10, 10, 2'd2, "prev2"};
    vecs[6]  = '{4'b1000, 10, 10, 2'd2, "key3_ignored"};
    vecs[7]  = '{4'b0100, 10, 10, 2'd0, "clear"};
    vecs[8]  = '{4'b0001, 10, 10, 2'd1, "next_after_clear"};
    vecs[9]  = '{4'b0011, 10, 10, 2'd1, "next_prev_same"};
    vecs[10] = '{4'b0001, 10, 10, 2'd2, "next_to_2"};
    vecs[11] = '{4'b0001, 10, 10, 2'd3, "next_to_3"};
    vecs[12] = '{4'b0101, 10, 10, 2'd0, "next_clear_same"};
    vecs[13] = '{4'b0001, 200, 10, 2'd1, "hold200"};

    key   = 4'hF;
    rst_n = 1'b0;
    cycles(3);
    chk("reset_value", int'(filter_type), 0);
    rst_n = 1'b1;
    cycles(5);
    chk("idle_after_reset", int'(filter_type), 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Short bounces never reach the stability count.
    bounce(10);
    key = 4'hF;
    cycles(20);
    chk("bounce_rejected", int'(filter_type), 1);

    bounce(10);
    key[0] = 1'b0;
    cycles(20);
    chk("bounce_then_low", int'(filter_type), 2);
    key = 4'hF;
    cycles(15);
    chk("bounce_release", int'(filter_type), 2);

    // Asynchronous reset from state 2, taken mid-cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'(filter_type), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    chk("reset_release_idle", int'(filter_type), 0);

    // Reset mid-debounce with key held: acts as a fresh press afterwards.
    key[0] = 1'b0;
    cycles(4);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_press", int'(filter_type), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(LAT - 1);
    chk("held_before_debounce", int'(filter_type), 0);
    cycles(1);
    chk("held_new_press", int'(filter_type), 1);
    cycles(20);
    key = 4'hF;
    cycles(15);
    chk("held_single_step", int'(filter_type), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
